// File: rtl/sort_pkg.sv
// Shared types and helpers for the bitonic sorter front end.
package sort_pkg;

  localparam int DEFAULT_NUM_COUNT  = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    PENDING = 1'b1
  } fill_state_e;

  typedef logic [$clog2(DEFAULT_NUM_COUNT)-1:0] lane_idx_t;

  // All-ones sorts to the top of an ascending sort, so pad lanes drift to the tail.
  localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_PAD = {DEFAULT_DATA_WIDTH{1'b1}};

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_batch_loader.sv
// Packs a word stream into NUM_COUNT-wide batches for the sorter, with one
// pending batch buffered behind the output slot.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// producer of valid holds its data stable until that edge; ready never depends
// combinationally on the other side's valid or ready.
module sort_batch_loader
  import sort_pkg::*;
#(
  parameter int                    NUM_COUNT  = DEFAULT_NUM_COUNT,
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = {DATA_WIDTH{1'b1}},
  localparam int                   IDX_W      = $clog2(NUM_COUNT),
  localparam int                   CW         = count_width(NUM_COUNT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [NUM_COUNT*DATA_WIDTH-1:0]  batch_data,
  output logic [CW-1:0]                    batch_count,
  output logic                             batch_last,
  output logic                             batch_valid,
  input  logic                             batch_ready,
  output fill_state_e                      fill_state
);

  fill_state_e                     state;
  logic [IDX_W-1:0]                idx;
  logic [NUM_COUNT*DATA_WIDTH-1:0] fill_buf;
  logic [CW-1:0]                   pend_count;
  logic                            pend_last;

  logic                            in_xfer;
  logic                            out_xfer;
  logic                            completing;
  logic                            slot_free;
  logic [NUM_COUNT*DATA_WIDTH-1:0] done_data;
  logic [CW-1:0]                   done_count;

  assign in_ready   = (state == FILLING) && !reset;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = batch_valid && batch_ready;
  assign completing = in_xfer && (in_last || (idx == IDX_W'(NUM_COUNT - 1)));
  assign slot_free  = !batch_valid || batch_ready;
  assign done_count = CW'(idx) + CW'(1);
  assign fill_state = state;

  // Batch as it would look if closed this cycle: earlier lanes, current word, pad above.
  always_comb begin
    done_data = fill_buf;
    for (int i = 0; i < NUM_COUNT; i++) begin
      if (i == int'(idx)) begin
        done_data[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end else if (i > int'(idx)) begin
        done_data[i*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILLING;
      idx         <= '0;
      fill_buf    <= '0;
      pend_count  <= '0;
      pend_last   <= 1'b0;
      batch_data  <= '0;
      batch_count <= '0;
      batch_last  <= 1'b0;
      batch_valid <= 1'b0;
    end else if (state == FILLING) begin
      if (completing) begin
        idx <= '0;
        if (slot_free) begin
          batch_data  <= done_data;
          batch_count <= done_count;
          batch_last  <= in_last;
          batch_valid <= 1'b1;
        end else begin
          fill_buf   <= done_data;
          pend_count <= done_count;
          pend_last  <= in_last;
          state      <= PENDING;
        end
      end else begin
        if (in_xfer) begin
          fill_buf[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
          idx <= idx + IDX_W'(1);
        end
        if (out_xfer) begin
          batch_valid <= 1'b0;
        end
      end
    end else begin
      // The slot is always occupied while a batch is pending.
      if (batch_ready) begin
        batch_data  <= fill_buf;
        batch_count <= pend_count;
        batch_last  <= pend_last;
        batch_valid <= 1'b1;
        state       <= FILLING;
      end
    end
  end

endmodule

// File: tb/tb_sort_batch_loader.sv
// Bench for sort_batch_loader: directed vector table, reset sequence, and a
// randomized run against a queue-based batch model.
module tb_sort_batch_loader;
  import sort_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BW = N * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [BW-1:0] batch_data;
  logic [2:0]    batch_count;
  logic          batch_last;
  logic          batch_valid;
  logic          batch_ready;
  fill_state_e   fill_state;

  int n_checks = 0;
  int n_fail   = 0;

  sort_batch_loader #(.NUM_COUNT(N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .batch_data  (batch_data),
    .batch_count (batch_count),
    .batch_last  (batch_last),
    .batch_valid (batch_valid),
    .batch_ready (batch_ready),
    .fill_state  (fill_state)
  );

  always #5 clk = ~clk;

  // Reference model: words collect into a list; a batch closes at N words or
  // on in_last, pads to all-ones, and queues as {last, count, data}.
  logic [DW-1:0]       cur_w[$];
  logic [BW+3+1-1:0]   exp_q[$];

  function automatic logic [BW+3:0] make_batch(input logic last_bit);
    logic [BW-1:0] d;
    d = '1;
    for (int i = 0; i < cur_w.size(); i++) d[i*DW +: DW] = cur_w[i];
    return {last_bit, 3'(cur_w.size()), d};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cur_w.delete();
      exp_q.delete();
    end else begin
      if (batch_valid && batch_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        cur_w.push_back(in_data);
        if (cur_w.size() == N || in_last) begin
          exp_q.push_back(make_batch(in_last));
          cur_w.delete();
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          vi;
    logic [DW-1:0] d;
    logic          l;
    logic          br;
    logic          bv;
    logic [BW-1:0] bd;
    logic [2:0]    bc;
    logic          bl;
    logic          ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vi, input logic [DW-1:0] d, input logic l,
                              input logic br, input logic bv, input logic [BW-1:0] bd,
                              input logic [2:0] bc, input logic bl, input logic ir);
    vec_t v;
    v.vi = vi; v.d = d; v.l = l; v.br = br;
    v.bv = bv; v.bd = bd; v.bc = bc; v.bl = bl; v.ir = ir;
    return v;
  endfunction

  task automatic drive(input logic vi, input logic [DW-1:0] d, input logic l, input logic br);
    in_valid = vi; in_data = d; in_last = l; batch_ready = br;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_valid", batch_valid, 0);
    check("reset_data", batch_data, 0);
    check("reset_count", batch_count, 0);
    check("reset_last", batch_last, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_state", fill_state, FILLING);
    reset = 1'b0;
    #1 check("release_in_ready", in_ready, 1);

    // Full batch, partial batch, lane-0 restart.
    vecs.push_back(mk(1, 8'h30, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h10, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h40, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h20, 0, 1, 1, 32'h20401030, 4, 0, 1));
    vecs.push_back(mk(1, 8'h05, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h07, 1, 1, 1, 32'hFFFF0705, 2, 1, 1));
    vecs.push_back(mk(1, 8'hAA, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'hBB, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'hCC, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'hDD, 0, 1, 1, 32'hDDCCBBAA, 4, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1));
    // Backpressure: slot plus pending fill, then in_ready drops.
    for (int i = 1; i <= 8; i++) begin
      if (i < 4)       vecs.push_back(mk(1, 8'(i), 0, 0, 0, 0, 0, 0, 1));
      else if (i < 8)  vecs.push_back(mk(1, 8'(i), 0, 0, 1, 32'h04030201, 4, 0, 1));
      else             vecs.push_back(mk(1, 8'(i), 0, 0, 1, 32'h04030201, 4, 0, 0));
    end
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 8'h09, 0, 0, 1, 32'h04030201, 4, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 32'h08070605, 4, 0, 1));
    vecs.push_back(mk(1, 8'h09, 0, 0, 1, 32'h08070605, 4, 0, 1));
    vecs.push_back(mk(1, 8'h0A, 0, 0, 1, 32'h08070605, 4, 0, 1));
    vecs.push_back(mk(1, 8'h0B, 0, 0, 1, 32'h08070605, 4, 0, 1));
    // Drain and completion on the same edge.
    vecs.push_back(mk(1, 8'h0C, 0, 1, 1, 32'h0C0B0A09, 4, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1));
    // in_last on the final lane, then a one-word batch.
    vecs.push_back(mk(1, 8'h11, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h22, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h33, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h44, 1, 1, 1, 32'h44332211, 4, 1, 1));
    vecs.push_back(mk(1, 8'h55, 1, 1, 1, 32'hFFFFFF55, 1, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1));

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].vi, vecs[k].d, vecs[k].l, vecs[k].br);
      @(negedge clk);
      check($sformatf("vec%0d_valid", k), batch_valid, vecs[k].bv);
      check($sformatf("vec%0d_in_ready", k), in_ready, vecs[k].ir);
      if (vecs[k].bv) begin
        check($sformatf("vec%0d_data", k), batch_data, vecs[k].bd);
        check($sformatf("vec%0d_count", k), batch_count, vecs[k].bc);
        check($sformatf("vec%0d_last", k), batch_last, vecs[k].bl);
      end
    end

    // Reset mid-fill with a batch waiting in the slot.
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'h61 + 8'(i), 0, 0);
      @(negedge clk);
    end
    check("pre_reset_valid", batch_valid, 1);
    drive(0, 8'h00, 0, 0);
    #2 reset = 1'b1;
    #1 check("async_reset_valid", batch_valid, 0);
    check("async_reset_in_ready", in_ready, 0);
    check("async_reset_count", batch_count, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 0, 1);
      @(negedge clk);
    end
    drive(0, 8'h00, 0, 1);
    check("post_reset_valid", batch_valid, 1);
    check("post_reset_data", batch_data, 32'h04030201);
    check("post_reset_count", batch_count, 4);
    @(negedge clk);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      check("rand_valid", batch_valid, exp_q.size() > 0);
      check("rand_in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() > 0) begin
        check("rand_data", batch_data, exp_q[0][BW-1:0]);
        check("rand_count", batch_count, exp_q[0][BW+2:BW]);
        check("rand_last", batch_last, exp_q[0][BW+3]);
      end
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_batch_loader.md
# sort_batch_loader

- Upstream feeder for the bitonic sorter.
- Accepts a one-word-per-cycle stream of `DATA_WIDTH`-bit keys and packs `NUM_COUNT` consecutive words into one wide batch vector.
- A partial final batch (`in_last` early) is padded with `PAD_VALUE`.
- The batch is presented on a valid/ready pair that connects directly to the sorter's `data_in`/`valid`/`ready`. A second buffer lets the next batch fill while the current one waits for the sorter.

## Interface
- `NUM_COUNT`, default 4: words per batch. Must be a power of two, ≥2.
- `DATA_WIDTH`, default 8: bits per word.
- `PAD_VALUE`, default all-ones: filler for unused lanes. Sorts to the top in an ascending sort.
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high. Clears all state immediately.
- `in_data`, input, `DATA_WIDTH`: stream word.
- `in_valid`, input, 1: `in_data` is valid.
- `in_last`, input, 1: this word closes the current batch.
- `in_ready`, output, 1: loader can accept a word this cycle.
- `batch_data`, output, `NUM_COUNT*DATA_WIDTH`: packed batch. Lane i is bits `[i*DATA_WIDTH +: DATA_WIDTH]`. The first word received goes in lane 0.
- `batch_count`, output, `$clog2(NUM_COUNT+1)`: number of real (non-pad) words, 1..`NUM_COUNT`.
- `batch_last`, output, 1: the batch was closed by `in_last`.
- `batch_valid`, output, 1: batch available. Drives the sorter's `valid`.
- `batch_ready`, input, 1: consumer accepts. Driven by the sorter's `ready`.

## Operation
- **Input transfer:** occurs when `in_valid && in_ready` at a rising edge.
- **Output transfer:** occurs when `batch_valid && batch_ready` at a rising edge.
- **Fill side FSM:**
  - **FILLING:** holds index `idx`, 0..`NUM_COUNT`-1.
    - Each input transfer writes lane `idx`.
    - A batch completes when the transfer has `idx == NUM_COUNT-1` or `in_last == 1`.
    - On completion, lanes `idx+1`..`NUM_COUNT-1` are set to `PAD_VALUE`, count = `idx+1`, and `last` = `in_last`.
  - **PENDING:** a completed batch is waiting because the output slot is occupied. `in_ready` = 0.
- **Output slot:** a single register set (`batch_data`, `batch_count`, `batch_last`, `batch_valid`).
- **Handover:** a completed batch moves into the output slot when the slot is empty or is being drained in the same cycle. Otherwise the fill side enters PENDING.
- **Transitions:**
  - FILLING → FILLING (`idx` + 1) on a non-completing transfer.
  - FILLING → FILLING (`idx` = 0) on completion with handover.
  - FILLING → PENDING on completion without handover.
  - PENDING → FILLING (`idx` = 0) on the cycle the output slot drains. The pending batch moves across on that edge.
- **Output stability:** `batch_data`, `batch_count` and `batch_last` are stable while `batch_valid` is high and no output transfer has occurred.
- **No empty batches:** zero-word batches are never produced. `in_last` only has effect on a transferred word.
- **`in_last` on a full batch:** `in_last` on lane `NUM_COUNT-1` yields count = `NUM_COUNT`, `last` = 1, no padding.

## Timing
- **Reset values:** `batch_valid` = 0, `batch_data` = 0, `batch_count` = 0, `batch_last` = 0, `idx` = 0, state FILLING. `in_ready` = 0 while `reset` is high.
- **Latency:** the completing input transfer at edge k, with the slot free, gives `batch_valid` = 1 after edge k. That is 1 cycle.
- **Throughput:** one word per cycle while not PENDING.
- **Waiting on the sorter:** the sorter takes several cycles per batch. If the slot and the pending buffer are both full, `in_ready` stays low until `batch_ready`.
- **`in_ready`:** purely a function of state, with no combinational path from `batch_ready` to `in_ready`. When PENDING, `in_ready` rises the cycle after the drain edge.
- **Simultaneous drain and completion:** `batch_valid` stays 1 and new data appears after the edge, with no bubble.
- **Unmatched handshakes:** `batch_ready` high with `batch_valid` low has no effect. `in_valid` high with `in_ready` low does not accept a word and does not advance `idx`.
- **Reset mid-operation:** partial and pending batches are discarded. The first word after release goes into lane 0.

## Structure
- **Package `sort_pkg`:**
  - fill-state enum (`FILLING`, `PENDING`);
  - `lane_idx_t` of width `$clog2(NUM_COUNT)`;
  - a count-width function;
  - a default pad constant.
- **Sub-modules:** none. The single module holds the fill register, pending flag and output slot. The pad mask is generated inline.

## Test plan
All scenarios use `NUM_COUNT` = 4, `DATA_WIDTH` = 8, and keep `batch_ready` = 1 unless stated.
- **Full batch:** stream 0x30, 0x10, 0x40, 0x20 back-to-back → one cycle after the 4th transfer, `batch_data` = 0x20401030, `batch_count` = 4, `batch_last` = 0, `batch_valid` = 1.
- **Partial batch:** stream 0x05, 0x07 with `in_last` on 0x07 → `batch_data` = 0xFFFF0705, `batch_count` = 2, `batch_last` = 1. The next word lands in lane 0.
- **Backpressure:** hold `batch_ready` = 0 and stream 12 words → 8 are accepted (slot + pending), `in_ready` = 0 after the 8th. Raise `batch_ready` for one cycle → the slot takes batch 2 with no bubble, and `in_ready` = 1 the next cycle.
- **Simultaneous drain and completion:** drive `batch_ready` = 1 on the same edge as a completing input → `batch_valid` stays high and the data switches to the new batch.
- **Reset mid-fill:** assert `reset` asynchronously after 2 words → `batch_valid` = 0 immediately. After release, 0x01..0x04 gives `batch_data` = 0x04030201.
- **Sorter integration:** connect to the sorter and stream 8 random words → two sorted batches come out, the padded tail lanes are 0xFF, and no word is lost or duplicated.
